// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types, defaults and I/O size codes
// for the I/D-cache and uncached memory arbiter.
package mem_arbiter_pkg;

  localparam int DEF_BLOCK_WIDTH = 4;
  localparam int DEF_BLOCK_SIZE = 2 ** DEF_BLOCK_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    IC_RD,
    DC_RD,
    DC_WR,
    IO_RD,
    IO_WR,
    DONE
  } arbState_t;

  localparam logic [1:0] IO_BYTE = 2'b01;
  localparam logic [1:0] IO_HALF = 2'b10;
  localparam logic [1:0] IO_WORD = 2'b11;

  function automatic logic [2:0] ioBytes(
    input logic [1:0] size
  );
    case (size)
      IO_BYTE: return 3'd1;
      IO_HALF: return 3'd2;
      IO_WORD: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and RAM bus bundle.
// slave = arbiter side, master = requesters/RAM side.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
);
  localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;

  logic clearIn;
  logic icReq;
  logic [31-BLOCK_WIDTH:0] icAddr;
  logic dcReq;
  logic dcWrite;
  logic [31-BLOCK_WIDTH:0] dcAddr;
  logic [BLOCK_SIZE*8-1:0] dcWData;
  logic ioReq;
  logic ioWrite;
  logic [1:0] ioSize;
  logic [31:0] ioAddr;
  logic [31:0] ioWData;
  logic [7:0] memIn;
  logic [31:0] memAddr;
  logic [7:0] memOut;
  logic memWrite;
  logic icDone;
  logic dcDone;
  logic ioDone;
  logic [BLOCK_SIZE*8-1:0] blkData;
  logic [31:0] ioRData;

  modport slave (
    input clearIn, icReq, icAddr,
    input dcReq, dcWrite, dcAddr, dcWData,
    input ioReq, ioWrite, ioSize,
    input ioAddr, ioWData, memIn,
    output memAddr, memOut, memWrite,
    output icDone, dcDone, ioDone,
    output blkData, ioRData
  );

  modport master (
    output clearIn, icReq, icAddr,
    output dcReq, dcWrite, dcAddr, dcWData,
    output ioReq, ioWrite, ioSize,
    output ioAddr, ioWData, memIn,
    input memAddr, memOut, memWrite,
    input icDone, dcDone, ioDone,
    input blkData, ioRData
  );

endinterface

// File: rtl/mem_byte_seq.sv
// mem_byte_seq: byte counter, RAM address/data generation and
// read-capture buffer shared by every transfer state.
module mem_byte_seq #(
  parameter int DW = 128,
  parameter int CW = 5
) (
  input  logic          clkIn,
  input  logic          resetIn,
  input  logic          start,
  input  logic          active,
  input  logic          isWrite,
  input  logic [31:0]   base,
  input  logic [DW-1:0] wData,
  input  logic [CW-1:0] len,
  input  logic [7:0]    memIn,
  output logic [31:0]   memAddr,
  output logic [7:0]    memOut,
  output logic          memWrite,
  output logic          last,
  output logic [DW-1:0] rData
);
  localparam int IW = $clog2(DW);

  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic [IW-1:0] wrLo;
  logic [IW-1:0] rdLo;
  logic drive;

  assign idx = cnt - 1'b1;
  assign wrLo = IW'({cnt, 3'b000});
  assign rdLo = IW'({idx, 3'b000});
  assign drive = active && (cnt < len);

  assign memWrite = drive && isWrite;
  assign memAddr = drive ? base + 32'(cnt) : '0;
  assign memOut = memWrite ? wData[wrLo +: 8] : '0;

  // Reads need one extra cycle for the RAM latency.
  assign last = active &&
    (cnt == (isWrite ? len - 1'b1 : len));

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      cnt <= '0;
      rData <= '0;
    end else begin
      cnt <= active ? cnt + 1'b1 : '0;
      if (start)
        rData <= '0;
      else if (active && !isWrite && cnt != '0)
        rData[rdLo +: 8] <= memIn;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM arbiter for IO > DC > IC.
// Define MEM_ARBITER_PERF_EN for busy/stall counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) (
  input logic clkIn,
  input logic resetIn,
`ifdef MEM_ARBITER_PERF_EN
  output logic [31:0] busyCycles,
  output logic [31:0] icStallCycles,
`endif
  mem_arbiter_if.slave bus
);
  localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;
  localparam int DW = BLOCK_SIZE * 8;
  localparam int CW = BLOCK_WIDTH + 1;

  arbState_t state;
  arbState_t nextState;
  arbState_t opState;
  logic active;
  logic isWrite;
  logic start;
  logic last;
  logic [31:0] base;
  logic [DW-1:0] wData;
  logic [DW-1:0] rData;
  logic [CW-1:0] len;

  assign start = (state == IDLE) && (nextState != IDLE);

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state <= IDLE;
      opState <= IDLE;
    end else begin
      state <= nextState;
      if (start)
        opState <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:
        if (bus.ioReq)
          nextState = bus.ioWrite ? IO_WR : IO_RD;
        else if (bus.dcReq)
          nextState = bus.dcWrite ? DC_WR : DC_RD;
        else if (bus.icReq && !bus.clearIn)
          nextState = IC_RD;
      IC_RD:
        if (bus.clearIn)
          nextState = IDLE;
        else if (last)
          nextState = DONE;
      DONE:
        nextState = IDLE;
      default:
        if (last)
          nextState = DONE;
    endcase
  end

  always_comb begin
    active = 1'b0;
    isWrite = 1'b0;
    base = '0;
    wData = '0;
    len = '0;
    unique case (state)
      IC_RD: begin
        active = 1'b1;
        base = {bus.icAddr, {BLOCK_WIDTH{1'b0}}};
        len = CW'(BLOCK_SIZE);
      end
      DC_RD, DC_WR: begin
        active = 1'b1;
        isWrite = (state == DC_WR);
        base = {bus.dcAddr, {BLOCK_WIDTH{1'b0}}};
        wData = bus.dcWData;
        len = CW'(BLOCK_SIZE);
      end
      IO_RD, IO_WR: begin
        active = 1'b1;
        isWrite = (state == IO_WR);
        base = bus.ioAddr;
        wData = DW'(bus.ioWData);
        len = CW'(ioBytes(bus.ioSize));
      end
      default: ;
    endcase
  end

  assign bus.icDone = (state == DONE) &&
    (opState == IC_RD);
  assign bus.dcDone = (state == DONE) &&
    (opState == DC_RD || opState == DC_WR);
  assign bus.ioDone = (state == DONE) &&
    (opState == IO_RD || opState == IO_WR);
  assign bus.blkData = rData;
  assign bus.ioRData = rData[31:0];

  mem_byte_seq #(
    .DW(DW),
    .CW(CW)
  ) uSeq (
    .clkIn(clkIn),
    .resetIn(resetIn),
    .start(start),
    .active(active),
    .isWrite(isWrite),
    .base(base),
    .wData(wData),
    .len(len),
    .memIn(bus.memIn),
    .memAddr(bus.memAddr),
    .memOut(bus.memOut),
    .memWrite(bus.memWrite),
    .last(last),
    .rData(rData)
  );

`ifdef MEM_ARBITER_PERF_EN
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      busyCycles <= '0;
      icStallCycles <= '0;
    end else begin
      if (state != IDLE)
        busyCycles <= busyCycles + 1'b1;
      if (bus.icReq && state != IC_RD)
        icStallCycles <= icStallCycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a
// one-cycle-latency RAM model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clkIn;
  logic resetIn;
  int checks;
  int errors;

  mem_arbiter_if bus ();

`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] busyCycles;
  logic [31:0] icStallCycles;
  mem_arbiter dut (
    .clkIn(clkIn),
    .resetIn(resetIn),
    .busyCycles(busyCycles),
    .icStallCycles(icStallCycles),
    .bus(bus)
  );
`else
  mem_arbiter dut (
    .clkIn(clkIn),
    .resetIn(resetIn),
    .bus(bus)
  );
`endif

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  function automatic logic [7:0] pat(input logic [31:0] a);
    case (a)
      32'h0003_0000: return 8'hAB;
      32'h0003_0001: return 8'hCD;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clkIn)
    bus.memIn <= pat(bus.memAddr);

  task automatic clearInputs;
    bus.clearIn = 0;
    bus.icReq = 0;
    bus.icAddr = '0;
    bus.dcReq = 0;
    bus.dcWrite = 0;
    bus.dcAddr = '0;
    bus.dcWData = '0;
    bus.ioReq = 0;
    bus.ioWrite = 0;
    bus.ioSize = 2'b00;
    bus.ioAddr = '0;
    bus.ioWData = '0;
  endtask

  task automatic test_reset;
    resetIn = 0;
    clearInputs();
    repeat (2) @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_memAddr got %h want 0", bus.memAddr);
    end
    checks++;
    if ({bus.memWrite, bus.memOut} !== 9'h0) begin
      errors++;
      $display("FAIL reset_memWr got %b/%h want 0/00",
        bus.memWrite, bus.memOut);
    end
    checks++;
    if ({bus.icDone, bus.dcDone, bus.ioDone} !== 3'b000) begin
      errors++;
      $display("FAIL reset_done got %b want 000",
        {bus.icDone, bus.dcDone, bus.ioDone});
    end
    checks++;
    if (bus.blkData !== '0 || bus.ioRData !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 0",
        bus.blkData, bus.ioRData);
    end
    resetIn = 1;
    @(negedge clkIn);
  endtask

  task automatic test_ic_read;
    logic [127:0] exp;
    logic [31:0] a;
    bus.icReq = 1;
    bus.icAddr = 28'h0000100;
    for (int k = 0; k < 16; k++) begin
      @(negedge clkIn);
      a = 32'h1000 + 32'(k);
      exp[8*k +: 8] = pat(a);
      checks++;
      if (bus.memAddr !== a || bus.memWrite !== 1'b0) begin
        errors++;
        $display("FAIL ic_addr k=%0d got %h/%b want %h/0",
          k, bus.memAddr, bus.memWrite, a);
      end
    end
    @(negedge clkIn);
    checks++;
    if (bus.icDone !== 1'b0) begin
      errors++;
      $display("FAIL ic_done16 got %b want 0", bus.icDone);
    end
    @(negedge clkIn);
    checks++;
    if (bus.icDone !== 1'b1) begin
      errors++;
      $display("FAIL ic_done17 got %b want 1", bus.icDone);
    end
    checks++;
    if (bus.blkData !== exp) begin
      errors++;
      $display("FAIL ic_blk got %h want %h", bus.blkData, exp);
    end
    bus.icReq = 0;
    @(negedge clkIn);
    checks++;
    if (bus.icDone !== 1'b0 || bus.blkData !== exp) begin
      errors++;
      $display("FAIL ic_hold got %b/%h want 0/%h",
        bus.icDone, bus.blkData, exp);
    end
  endtask

  task automatic test_priority;
    logic [31:0] expIo;
    logic [127:0] expBlk;
    int n;
    for (int k = 0; k < 4; k++)
      expIo[8*k +: 8] = pat(32'h400 + 32'(k));
    for (int k = 0; k < 16; k++)
      expBlk[8*k +: 8] = pat(32'h3000 + 32'(k));
    bus.ioReq = 1;
    bus.ioWrite = 0;
    bus.ioSize = IO_WORD;
    bus.ioAddr = 32'h400;
    bus.dcReq = 1;
    bus.dcWrite = 0;
    bus.dcAddr = 28'h0000300;
    @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h400) begin
      errors++;
      $display("FAIL prio_io_first got %h want 400", bus.memAddr);
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clkIn);
      checks++;
      if (bus.ioDone !== (c == 5) || bus.dcDone !== 1'b0) begin
        errors++;
        $display("FAIL prio_io_done c=%0d got %b/%b want %b/0",
          c, bus.ioDone, bus.dcDone, c == 5);
      end
    end
    checks++;
    if (bus.ioRData !== expIo) begin
      errors++;
      $display("FAIL prio_io_data got %h want %h",
        bus.ioRData, expIo);
    end
    bus.ioReq = 0;
    @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h0) begin
      errors++;
      $display("FAIL prio_idle got %h want 0", bus.memAddr);
    end
    @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h3000) begin
      errors++;
      $display("FAIL prio_dc_grant got %h want 3000", bus.memAddr);
    end
    n = 0;
    while (bus.dcDone !== 1'b1 && n < 30) begin
      @(negedge clkIn);
      n++;
    end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL prio_dc_lat got %0d want 17", n);
    end
    checks++;
    if (bus.blkData !== expBlk) begin
      errors++;
      $display("FAIL prio_dc_blk got %h want %h",
        bus.blkData, expBlk);
    end
    bus.dcReq = 0;
    @(negedge clkIn);
  endtask

  task automatic test_dc_write;
    logic [31:0] a;
    bus.dcReq = 1;
    bus.dcWrite = 1;
    bus.dcAddr = 28'h0000200;
    for (int k = 0; k < 16; k++)
      bus.dcWData[8*k +: 8] = 8'(k);
    for (int k = 0; k < 16; k++) begin
      @(negedge clkIn);
      a = 32'h2000 + 32'(k);
      checks++;
      if (bus.memAddr !== a || bus.memWrite !== 1'b1 ||
          bus.memOut !== 8'(k) || bus.dcDone !== 1'b0) begin
        errors++;
        $display("FAIL dcw_beat k=%0d got %h/%b/%h want %h/1/%h",
          k, bus.memAddr, bus.memWrite, bus.memOut, a, 8'(k));
      end
    end
    @(negedge clkIn);
    checks++;
    if (bus.memWrite !== 1'b0 || bus.dcDone !== 1'b1) begin
      errors++;
      $display("FAIL dcw_done got wr=%b done=%b want 0/1",
        bus.memWrite, bus.dcDone);
    end
    bus.dcReq = 0;
    bus.dcWrite = 0;
    @(negedge clkIn);
  endtask

  task automatic test_io_half;
    bus.ioReq = 1;
    bus.ioWrite = 0;
    bus.ioSize = IO_HALF;
    bus.ioAddr = 32'h30000;
    @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h30000) begin
      errors++;
      $display("FAIL ioh_a0 got %h want 30000", bus.memAddr);
    end
    @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h30001) begin
      errors++;
      $display("FAIL ioh_a1 got %h want 30001", bus.memAddr);
    end
    @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h0 || bus.ioDone !== 1'b0) begin
      errors++;
      $display("FAIL ioh_c2 got %h/%b want 0/0",
        bus.memAddr, bus.ioDone);
    end
    @(negedge clkIn);
    checks++;
    if (bus.ioDone !== 1'b1 || bus.ioRData !== 32'h0000CDAB) begin
      errors++;
      $display("FAIL ioh_done got %b/%h want 1/0000cdab",
        bus.ioDone, bus.ioRData);
    end
    bus.ioReq = 0;
    @(negedge clkIn);
  endtask

  task automatic test_io_write_wrap;
    logic [31:0] a;
    logic [31:0] d;
    bus.ioReq = 1;
    bus.ioWrite = 1;
    bus.ioSize = IO_WORD;
    bus.ioAddr = 32'hFFFF_FFFE;
    bus.ioWData = 32'h4433_2211;
    d = 32'h4433_2211;
    for (int k = 0; k < 4; k++) begin
      @(negedge clkIn);
      a = 32'hFFFF_FFFE + 32'(k);
      checks++;
      if (bus.memAddr !== a || bus.memWrite !== 1'b1 ||
          bus.memOut !== d[8*k +: 8]) begin
        errors++;
        $display("FAIL iow_beat k=%0d got %h/%b/%h want %h/1/%h",
          k, bus.memAddr, bus.memWrite, bus.memOut,
          a, d[8*k +: 8]);
      end
    end
    @(negedge clkIn);
    checks++;
    if (bus.ioDone !== 1'b1 || bus.memWrite !== 1'b0) begin
      errors++;
      $display("FAIL iow_done got %b/%b want 1/0",
        bus.ioDone, bus.memWrite);
    end
    bus.ioReq = 0;
    bus.ioWrite = 0;
    @(negedge clkIn);
  endtask

  task automatic test_clear_ic;
    int n;
    logic icSeen;
    bus.icReq = 1;
    bus.icAddr = 28'h0000500;
    @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h5000) begin
      errors++;
      $display("FAIL clr_grant got %h want 5000", bus.memAddr);
    end
    bus.dcReq = 1;
    bus.dcWrite = 0;
    bus.dcAddr = 28'h0000600;
    for (int c = 1; c <= 5; c++)
      @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h5005) begin
      errors++;
      $display("FAIL clr_c5 got %h want 5005", bus.memAddr);
    end
    bus.clearIn = 1;
    @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h0 || bus.icDone !== 1'b0 ||
        bus.memWrite !== 1'b0) begin
      errors++;
      $display("FAIL clr_abort got %h/%b/%b want 0/0/0",
        bus.memAddr, bus.icDone, bus.memWrite);
    end
    bus.clearIn = 0;
    bus.icReq = 0;
    @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h6000) begin
      errors++;
      $display("FAIL clr_dc_next got %h want 6000", bus.memAddr);
    end
    n = 0;
    icSeen = 0;
    while (bus.dcDone !== 1'b1 && n < 30) begin
      if (bus.icDone === 1'b1)
        icSeen = 1;
      @(negedge clkIn);
      n++;
    end
    checks++;
    if (n != 17 || icSeen !== 1'b0) begin
      errors++;
      $display("FAIL clr_dc_done got lat=%0d ic=%b want 17/0",
        n, icSeen);
    end
    bus.dcReq = 0;
    @(negedge clkIn);
  endtask

  task automatic test_clear_idle_reset;
    int n;
    bus.clearIn = 1;
    bus.icReq = 1;
    bus.icAddr = 28'h0000700;
    @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h0) begin
      errors++;
      $display("FAIL clr_idle_mask got %h want 0", bus.memAddr);
    end
    bus.clearIn = 0;
    @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h7000) begin
      errors++;
      $display("FAIL clr_idle_grant got %h want 7000",
        bus.memAddr);
    end
    repeat (2) @(negedge clkIn);
    resetIn = 0;
    #1;
    checks++;
    if (bus.memAddr !== 32'h0 || bus.memWrite !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got %h/%b want 0/0",
        bus.memAddr, bus.memWrite);
    end
    @(negedge clkIn);
    checks++;
    if (bus.icDone !== 1'b0 || bus.blkData !== '0) begin
      errors++;
      $display("FAIL rst_mid_done got %b/%h want 0/0",
        bus.icDone, bus.blkData);
    end
    resetIn = 1;
    @(negedge clkIn);
    checks++;
    if (bus.memAddr !== 32'h7000) begin
      errors++;
      $display("FAIL rst_regrant got %h want 7000", bus.memAddr);
    end
    n = 0;
    while (bus.icDone !== 1'b1 && n < 30) begin
      @(negedge clkIn);
      n++;
    end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL rst_ic_lat got %0d want 17", n);
    end
    bus.icReq = 0;
    @(negedge clkIn);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ic_read();
    test_priority();
    test_dc_write();
    test_io_half();
    test_io_write_wrap();
    test_clear_ic();
    test_clear_idle_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BLOCK_WIDTH, default 4, log2 of the cache block size in bytes (BLOCK_SIZE = 2**BLOCK_WIDTH = 16).
REQ-002 clkIn  input  1  system clock; all state updates on the rising edge.
REQ-003 resetIn  input  1  asynchronous, active-low reset.
REQ-004 clearIn  input  1  wrong-branch-prediction flush.
REQ-005 icReq  input  1  ICache block refill request.
REQ-006 icAddr  input  32-BLOCK_WIDTH  ICache block address.
REQ-007 dcReq  input  1  DCache block request.
REQ-008 dcWrite  input  1  DCache operation: 1 = write-back, 0 = refill.
REQ-009 dcAddr  input  32-BLOCK_WIDTH  DCache block address.
REQ-010 dcWData  input  BLOCK_SIZE*8  DCache write-back data, byte k at bits [8k+7:8k].
REQ-011 ioReq, ioWrite  input  1 each  uncached (I/O) access request and write select.
REQ-012 ioSize  input  2  access size: 01 byte, 10 half word, 11 word.
REQ-013 ioAddr, ioWData  input  32 each  I/O address and write data.
REQ-014 memIn  input  8  RAM read byte, valid one cycle after its address.
REQ-015 memAddr  output  32  RAM address.
REQ-016 memOut  output  8  RAM write byte.
REQ-017 memWrite  output  1  RAM write strobe (1 = write).
REQ-018 icDone, dcDone, ioDone  output  1 each  single-cycle completion pulses.
REQ-019 blkData  output  BLOCK_SIZE*8  refill data, valid while icDone or dcDone is high.
REQ-020 ioRData  output  32  I/O read data, zero-extended, valid while ioDone is high.

Function
REQ-021 States: IDLE, IC_RD, DC_RD, DC_WR, IO_RD, IO_WR, DONE; arbitration happens only in IDLE; grants are non-preemptive.
REQ-022 Priority in IDLE SHALL be ioReq > dcReq > icReq; the granted state is entered on the next edge.
REQ-023 Block read: address base+k is driven in transfer cycle k (k = 0..15) with memWrite=0; the byte on memIn in cycle k+1 is captured into blkData byte k; the done pulse is raised in cycle 17.
REQ-024 Block write: cycle k drives memAddr = base+k, memOut = byte k, memWrite = 1; memWrite = 0 from cycle 16; dcDone is raised in cycle 16.
REQ-025 I/O access: N = 1, 2 or 4 bytes, little-endian, at addresses ioAddr+k; read and write timing follows REQ-023/REQ-024 with N in place of 16; unread bytes of ioRData are 0.
REQ-026 The done pulse is issued in DONE; DONE always returns to IDLE; a requester still asserting req during DONE is not re-granted in that cycle.
REQ-027 Requesters hold req and their operands stable from assertion until the done pulse; blkData and ioRData are held until the next grant.
REQ-028 clearIn during IC_RD SHALL abort the refill: next state IDLE, no icDone, memWrite stays 0.
REQ-029 clearIn in IDLE masks icReq for that cycle; DC_* and IO_* transfers are never aborted.
REQ-030 Block addresses wrap modulo 2**32; an I/O access whose address +3 crosses 0xFFFFFFFF wraps to 0.

Reset
REQ-031 While resetIn = 0: state = IDLE, memWrite = 0, memAddr = 0, memOut = 0, all done pulses = 0, blkData = 0, ioRData = 0.
REQ-032 Reset mid-transfer abandons the transfer with no done pulse; the first grant is possible on the first edge after release.

Configuration
REQ-033 With MEM_ARBITER_PERF_EN defined: outputs busyCycles and icStallCycles (32 bits each, wrapping) count, respectively, cycles not in IDLE and cycles where icReq = 1 while not in IC_RD.
REQ-034 Without MEM_ARBITER_PERF_EN: the counters and their ports are absent; all other behaviour is identical.

Structure
REQ-035 Package mem_arbiter_pkg holds the state enum, BLOCK_WIDTH/BLOCK_SIZE defaults, and the ioSize encodings.
REQ-036 Sub-module mem_byte_seq (byte counter, address/data generation, capture shift) is shared by all transfer states.

Verification
REQ-037 icReq, icAddr=0x0000100 -> memAddr 0x1000..0x100F over cycles 0-15; icDone in cycle 17; blkData equals the RAM contents.
REQ-038 ioReq and dcReq both asserted in IDLE -> IO granted first; DC granted in the IDLE cycle after ioDone.
REQ-039 dcWrite=1, dcAddr=0x0000200, dcWData byte k = k -> 16 writes of 0x00..0x0F to 0x2000..0x200F; dcDone in cycle 16.
REQ-040 ioSize=10 read at 0x30000 with RAM bytes 0xAB, 0xCD -> ioRData = 0x0000CDAB.
REQ-041 clearIn in IC_RD cycle 5 -> IDLE, no icDone; a pending dcReq is granted next.
